// File: rtl/cordic_rotator.sv
// rtl/cordic_rotator.sv - fully pipelined rotation-mode CORDIC, first-quadrant angle to cos/sin in Q1.15
module cordic_rotator #(
  parameter int D_WIDTH = 16,
  parameter int ITER    = D_WIDTH - 1,
  parameter int GUARD   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] z_tgt,
  output logic [D_WIDTH-1:0] x_out,
  output logic [D_WIDTH-1:0] y_out
);

  localparam int IW = D_WIDTH + GUARD + 2;

  // Pre-scaled by the CORDIC gain so the final vector has unit magnitude.
  localparam logic signed [IW-1:0] X_INIT = IW'(19898 << GUARD);
  localparam logic signed [IW-1:0] RND    = IW'(1 << (GUARD - 1));
  localparam logic signed [IW-1:0] ONE    = IW'(1 << (D_WIDTH - 1));

  function automatic logic signed [IW-1:0] atan_lut(input int idx);
    logic [15:0] a;
    case (idx)
      0:       a = 16'd16384;
      1:       a = 16'd9672;
      2:       a = 16'd5110;
      3:       a = 16'd2594;
      4:       a = 16'd1302;
      5:       a = 16'd652;
      6:       a = 16'd326;
      7:       a = 16'd163;
      8:       a = 16'd81;
      9:       a = 16'd41;
      10:      a = 16'd20;
      11:      a = 16'd10;
      12:      a = 16'd5;
      13:      a = 16'd3;
      14:      a = 16'd1;
      default: a = 16'd0;
    endcase
    return $signed({{(IW-16-GUARD){1'b0}}, a, {GUARD{1'b0}}});
  endfunction

  // Drop guard bits (round half up) and clamp into 0..1.0.
  function automatic logic [D_WIDTH-1:0] to_q15(input logic signed [IW-1:0] v);
    logic signed [IW-1:0] r;
    r = (v + RND) >>> GUARD;
    if (r[IW-1]) begin
      r = '0;
    end else if (r > ONE) begin
      r = ONE;
    end
    return D_WIDTH'(r);
  endfunction

  logic signed [IW-1:0] x_q [ITER];
  logic signed [IW-1:0] y_q [ITER];
  logic signed [IW-1:0] z_q [ITER];
  logic signed [IW-1:0] x_d [ITER];
  logic signed [IW-1:0] y_d [ITER];
  logic signed [IW-1:0] z_d [ITER];

  logic [D_WIDTH-1:0] x_out_q, x_out_d;
  logic [D_WIDTH-1:0] y_out_q, y_out_d;

  logic signed [IW-1:0] xs, ys, zs;
  logic signed [IW-1:0] z_init;

  assign z_init = $signed({{(IW-D_WIDTH-GUARD){1'b0}}, z_tgt, {GUARD{1'b0}}});

  // Stage 0 works straight off the input so the output register is edge ITER.
  always_comb begin
    xs = '0;
    ys = '0;
    zs = '0;
    for (int i = 0; i < ITER; i++) begin
      x_d[i] = '0;
      y_d[i] = '0;
      z_d[i] = '0;
    end
    for (int i = 0; i < ITER; i++) begin
      if (i == 0) begin
        xs = X_INIT;
        ys = '0;
        zs = z_init;
      end else begin
        xs = x_q[i-1];
        ys = y_q[i-1];
        zs = z_q[i-1];
      end
      if (!zs[IW-1]) begin
        x_d[i] = xs - (ys >>> i);
        y_d[i] = ys + (xs >>> i);
        z_d[i] = zs - atan_lut(i);
      end else begin
        x_d[i] = xs + (ys >>> i);
        y_d[i] = ys - (xs >>> i);
        z_d[i] = zs + atan_lut(i);
      end
    end
  end

  always_comb begin
    x_out_d = to_q15(x_q[ITER-1]);
    y_out_d = to_q15(y_q[ITER-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ITER; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
        z_q[i] <= '0;
      end
      x_out_q <= '0;
      y_out_q <= '0;
    end else begin
      for (int i = 0; i < ITER; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
        z_q[i] <= z_d[i];
      end
      x_out_q <= x_out_d;
      y_out_q <= y_out_d;
    end
  end

  assign x_out = x_out_q;
  assign y_out = y_out_q;

endmodule

// File: tb/tb_cordic_rotator.sv
// tb/tb_cordic_rotator.sv - scoreboard bench for cordic_rotator
module tb_cordic_rotator;

  localparam int LAT = 15;
  localparam real PI = 3.14159265358979;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] z_tgt = '0;
  logic [15:0] x_out;
  logic [15:0] y_out;

  always #5 clk = ~clk;

  cordic_rotator dut (
    .clk   (clk),
    .rst   (rst),
    .z_tgt (z_tgt),
    .x_out (x_out),
    .y_out (y_out)
  );

  typedef struct {
    int edge_no;
    int ex;
    int ey;
    bit acc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   edge_cnt = 0;
  bit   live = 1'b0;

  task automatic check_val(input string tag, input int obs, input int exp, input int tol);
    int diff;
    n_checks++;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at edge %0d", tag, obs, exp, tol, edge_cnt);
    end
  endtask

  function automatic int ref_cos(input int z);
    real a;
    a = real'(z) * PI / 65536.0;
    return int'(32768.0 * $cos(a));
  endfunction

  function automatic int ref_sin(input int z);
    real a;
    a = real'(z) * PI / 65536.0;
    return int'(32768.0 * $sin(a));
  endfunction

  task automatic cycle(input int z);
    exp_t e;
    z_tgt = 16'(z);
    @(posedge clk);
    edge_cnt++;
    if (!rst) begin
      e.edge_no = edge_cnt;
      e.ex      = ref_cos(z);
      e.ey      = ref_sin(z);
      e.acc     = (z < 32768);
      sb.push_back(e);
    end
    @(negedge clk);
    if (sb.size() > 0 && sb[0].edge_no + LAT == edge_cnt) begin
      e = sb.pop_front();
      live = 1'b1;
      if (e.acc) begin
        check_val("x_acc", int'(x_out), e.ex, 16);
        check_val("y_acc", int'(y_out), e.ey, 16);
      end
      check_val("x_range", int'(x_out <= 16'd32768), 1, 0);
      check_val("y_range", int'(y_out <= 16'd32768), 1, 0);
    end else if (!live) begin
      check_val("x_zero", int'(x_out), 0, 0);
      check_val("y_zero", int'(y_out), 0, 0);
    end
  endtask

  task automatic do_reset(input int cycles, input int z);
    rst = 1'b1;
    #1;
    check_val("x_rst_async", int'(x_out), 0, 0);
    check_val("y_rst_async", int'(y_out), 0, 0);
    sb.delete();
    live = 1'b0;
    repeat (cycles) cycle(z);
    rst = 1'b0;
  endtask

  initial begin
    #2;
    do_reset(4, 0);

    repeat (20) cycle(0);

    repeat (3) cycle(16384);
    repeat (2) cycle(5461);
    repeat (2) cycle(32767);
    cycle(40000);
    cycle(65535);
    cycle(32768);

    for (int z = 0; z <= 31000; z += 1000) cycle(z);
    cycle(0);
    for (int z = 500; z <= 12500; z += 1000) cycle(z);

    do_reset(3, 7000);
    for (int z = 13000; z <= 31000; z += 1500) cycle(z);
    cycle(0);
    for (int i = 0; i < 10; i++) cycle(int'($urandom_range(0, 32767)));

    repeat (LAT) cycle(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
